// File: rtl/ram_io_responder_pkg.sv
// Shared address map, region type and defaults for ram_io_responder and byte_fifo.
package ram_io_responder_pkg;

    localparam int          TX_FIFO_DEPTH_DEF = 16;
    localparam logic [17:0] IO_DATA_ADDR      = 18'h30000;
    localparam logic [17:0] IO_CNT_ADDR       = 18'h30004;

    typedef enum logic [1:0] {
        REGION_RAM,
        REGION_IO,
        REGION_UNMAPPED
    } region_e;

    function automatic region_e decode_region(input logic [17:0] addr);
        if (addr[17:16] == 2'b11)
            return REGION_IO;
        else if (!addr[17])
            return REGION_RAM;
        else
            return REGION_UNMAPPED;
    endfunction

endpackage

// File: rtl/ram_io_responder_byte_fifo.sv
// Byte-wide synchronous FIFO; a pop and a push in the same cycle are accepted even when full.
module byte_fifo
    import ram_io_responder_pkg::*;
#(
    parameter int DEPTH = TX_FIFO_DEPTH_DEF
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     i_push,
    input  logic [7:0]               i_data,
    input  logic                     i_pop,
    output logic [7:0]               o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [7:0]       r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (PTR_W+1)'(DEPTH));
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    always_ff @(posedge clk_in) begin
        if (w_do_push)
            r_mem[r_wr_ptr] <= i_data;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ram_io_responder.sv
// CPU-facing RAM plus memory-mapped UART rx/tx, stop register and program_done flag.
// Optional cycle counter at 0x30004-0x30007: define RAM_IO_CYCLE_COUNTER_EN.
module ram_io_responder
    import ram_io_responder_pkg::*;
#(
    parameter int RAM_ADDR_W    = 17,
    parameter int TX_FIFO_DEPTH = TX_FIFO_DEPTH_DEF
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        cpu_rdy,
    input  logic [31:0] mem_a,
    input  logic [7:0]  mem_dout,
    input  logic        mem_wr,
    output logic [7:0]  mem_din,
    output logic        io_buffer_full,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        program_done
);
    localparam int CNT_W = $clog2(TX_FIFO_DEPTH) + 1;

    logic [7:0]       r_ram [2**RAM_ADDR_W];
    logic [7:0]       r_ram_rd;
    logic [7:0]       r_io_rd;
    logic             r_sel_ram;
    logic             r_rx_full;
    logic [7:0]       r_rx_byte;
    logic             r_stop_pending;
    logic             r_done;

    logic [17:0]      w_addr;
    region_e          w_region;
    logic             w_rd;
    logic             w_wr;
    logic             w_sel_data;
    logic             w_sel_stop;
    logic             w_tx_push;
    logic             w_tx_pop;
    logic             w_rx_pop;
    logic             w_rx_capture;
    logic [7:0]       w_tx_din;
    logic [7:0]       w_io_rd;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic [CNT_W-1:0] w_fifo_count;
    logic             w_unused;

    assign w_addr       = mem_a[17:0];
    assign w_region     = decode_region(w_addr);
    assign w_rd         = cpu_rdy & ~mem_wr;
    assign w_wr         = cpu_rdy & mem_wr;
    assign w_sel_data   = (w_addr == IO_DATA_ADDR);
    assign w_sel_stop   = (w_addr == IO_CNT_ADDR);
    assign w_unused     = ^{mem_a[31:18], w_fifo_full};

    // Once a stop is pending the tx stream is closed; the stop marker itself is a 0x00 byte.
    assign w_tx_push    = w_wr & ~r_stop_pending & ((w_sel_data & (|mem_dout)) | w_sel_stop);
    assign w_tx_din     = w_sel_stop ? 8'h00 : mem_dout;
    assign w_tx_pop     = tx_valid & tx_ready;
    assign w_rx_pop     = w_rd & w_sel_data & r_rx_full;
    assign w_rx_capture = rx_valid & ~r_rx_full;

    assign rx_ready       = ~r_rx_full;
    assign program_done   = r_done;
    assign tx_valid       = ~w_fifo_empty;
    assign io_buffer_full = (w_fifo_count >= CNT_W'(TX_FIFO_DEPTH - 2));
    assign mem_din        = r_sel_ram ? r_ram_rd : r_io_rd;

`ifdef RAM_IO_CYCLE_COUNTER_EN
    logic [31:0] r_cycle_cnt;
    logic [31:0] r_snap;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_cycle_cnt <= '0;
            r_snap      <= '0;
        end else begin
            r_cycle_cnt <= r_cycle_cnt + 32'd1;
            if (w_rd && w_sel_stop)
                r_snap <= r_cycle_cnt;
        end
    end
`endif

    always_comb begin
        w_io_rd = 8'h00;
        if (w_sel_data && r_rx_full)
            w_io_rd = r_rx_byte;
`ifdef RAM_IO_CYCLE_COUNTER_EN
        // Byte 0 returns the live count; bytes 1-3 come from the snapshot it took.
        if (w_addr[17:2] == IO_CNT_ADDR[17:2]) begin
            case (w_addr[1:0])
                2'd0:    w_io_rd = r_cycle_cnt[7:0];
                2'd1:    w_io_rd = r_snap[15:8];
                2'd2:    w_io_rd = r_snap[23:16];
                default: w_io_rd = r_snap[31:24];
            endcase
        end
`endif
    end

    always_ff @(posedge clk_in) begin
        if (w_region == REGION_RAM) begin
            if (w_wr)
                r_ram[mem_a[RAM_ADDR_W-1:0]] <= mem_dout;
            if (w_rd)
                r_ram_rd <= r_ram[mem_a[RAM_ADDR_W-1:0]];
        end
    end

    always_ff @(posedge clk_in) begin
        if (w_rx_capture)
            r_rx_byte <= rx_data;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_sel_ram      <= 1'b0;
            r_io_rd        <= 8'h00;
            r_rx_full      <= 1'b0;
            r_stop_pending <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            if (w_rd) begin
                r_sel_ram <= (w_region == REGION_RAM);
                r_io_rd   <= w_io_rd;
            end
            if (w_rx_pop)
                r_rx_full <= 1'b0;
            else if (w_rx_capture)
                r_rx_full <= 1'b1;
            if (w_wr && w_sel_stop)
                r_stop_pending <= 1'b1;
            if (r_stop_pending && w_fifo_empty)
                r_done <= 1'b1;
        end
    end

    byte_fifo #(
        .DEPTH (TX_FIFO_DEPTH)
    ) u_tx_fifo (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .i_push  (w_tx_push),
        .i_data  (w_tx_din),
        .i_pop   (w_tx_pop),
        .o_data  (tx_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

endmodule

// File: tb/tb_ram_io_responder.sv
// Self-checking bench for ram_io_responder: directed scenarios plus randomized traffic vs. a queue-based model.
module tb_ram_io_responder;
    localparam int DEPTH = 16;

    logic        clk_in   = 1'b0;
    logic        rst_in   = 1'b0;
    logic        cpu_rdy  = 1'b0;
    logic [31:0] mem_a    = '0;
    logic [7:0]  mem_dout = '0;
    logic        mem_wr   = 1'b0;
    logic [7:0]  rx_data  = '0;
    logic        rx_valid = 1'b0;
    logic        tx_ready = 1'b0;
    logic [7:0]  mem_din;
    logic        io_buffer_full;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        program_done;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state
    logic [7:0]  m_ram [int];
    logic [7:0]  m_q [$];
    logic        m_rx_full;
    logic [7:0]  m_rx_byte;
    logic        m_stop;
    logic        m_done;
    logic [7:0]  m_din;
    logic [31:0] m_cnt;
    logic [31:0] m_snap;
    logic [7:0]  dut_sent [$];
    logic [31:0] pool [8];

    ram_io_responder dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .cpu_rdy        (cpu_rdy),
        .mem_a          (mem_a),
        .mem_dout       (mem_dout),
        .mem_wr         (mem_wr),
        .mem_din        (mem_din),
        .io_buffer_full (io_buffer_full),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .program_done   (program_done)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) begin
        if (rst_in && tx_valid && tx_ready)
            dut_sent.push_back(tx_data);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_in   = 1'b0;
        cpu_rdy  = 1'b0;
        mem_wr   = 1'b0;
        rx_valid = 1'b0;
        tx_ready = 1'b0;
        m_q.delete();
        m_rx_full = 1'b0;
        m_stop    = 1'b0;
        m_done    = 1'b0;
        m_din     = 8'h00;
        m_snap    = '0;
        repeat (2) @(posedge clk_in);
        #1;
        chk("rst_mem_din", 32'(mem_din), 32'h0);
        chk("rst_tx_valid", 32'(tx_valid), 32'h0);
        chk("rst_io_full", 32'(io_buffer_full), 32'h0);
        chk("rst_rx_ready", 32'(rx_ready), 32'h1);
        chk("rst_done", 32'(program_done), 32'h0);
        rst_in = 1'b1;
        m_cnt  = '0;
        dut_sent.delete();
    endtask

    // One clock: drive, check state-derived outputs, step the model, check read data after the edge.
    task automatic cycle(input logic rdy, input logic [31:0] a, input logic wr, input logic [7:0] d,
                         input logic rxv, input logic [7:0] rxd, input logic txr);
        logic [17:0] la;
        logic        pop, push_req, stop_set, rx_pop, done_next;
        logic [7:0]  push_val;
        int          size_before;
        cpu_rdy  = rdy;
        mem_a    = a;
        mem_wr   = wr;
        mem_dout = d;
        rx_valid = rxv;
        rx_data  = rxd;
        tx_ready = txr;
        #1;
        chk("tx_valid", 32'(tx_valid), 32'(m_q.size() != 0));
        if (m_q.size() != 0)
            chk("tx_data", 32'(tx_data), 32'(m_q[0]));
        chk("io_full", 32'(io_buffer_full), 32'(m_q.size() >= DEPTH - 2));
        chk("rx_ready", 32'(rx_ready), 32'(!m_rx_full));
        chk("done", 32'(program_done), 32'(m_done));

        la        = a[17:0];
        pop       = (m_q.size() != 0) && txr;
        done_next = m_done || (m_stop && m_q.size() == 0);
        push_req  = 1'b0;
        push_val  = 8'h00;
        stop_set  = 1'b0;
        rx_pop    = 1'b0;
        if (rdy && !wr) begin
            if (!la[17])
                m_din = m_ram[int'(la[16:0])];
            else if (la[17:16] == 2'b11) begin
                m_din = 8'h00;
                if (la == 18'h30000) begin
                    if (m_rx_full) m_din = m_rx_byte;
                    rx_pop = m_rx_full;
                end
`ifdef RAM_IO_CYCLE_COUNTER_EN
                if (la == 18'h30004) begin
                    m_din  = m_cnt[7:0];
                    m_snap = m_cnt;
                end
                else if (la == 18'h30005) m_din = m_snap[15:8];
                else if (la == 18'h30006) m_din = m_snap[23:16];
                else if (la == 18'h30007) m_din = m_snap[31:24];
`endif
            end
            else
                m_din = 8'h00;
        end
        if (rdy && wr) begin
            if (!la[17])
                m_ram[int'(la[16:0])] = d;
            if (la == 18'h30000 && d != 8'h00 && !m_stop) begin
                push_req = 1'b1;
                push_val = d;
            end
            if (la == 18'h30004) begin
                push_req = !m_stop;
                stop_set = 1'b1;
            end
        end
        if (rx_pop)
            m_rx_full = 1'b0;
        else if (rxv && !m_rx_full) begin
            m_rx_full = 1'b1;
            m_rx_byte = rxd;
        end
        size_before = m_q.size();
        if (pop)
            void'(m_q.pop_front());
        if (push_req && (size_before < DEPTH || pop))
            m_q.push_back(push_val);
        if (stop_set)
            m_stop = 1'b1;
        m_done = done_next;

        @(posedge clk_in);
        #1;
        m_cnt = m_cnt + 32'd1;
        chk("mem_din", 32'(mem_din), 32'(m_din));
    endtask

    task automatic idle(input logic txr);
        cycle(1'b0, 32'h0, 1'b0, 8'h00, 1'b0, 8'h00, txr);
    endtask

    task automatic wr_cyc(input logic [31:0] a, input logic [7:0] d, input logic txr);
        cycle(1'b1, a, 1'b1, d, 1'b0, 8'h00, txr);
    endtask

    task automatic rd_cyc(input logic [31:0] a, input logic txr);
        cycle(1'b1, a, 1'b0, 8'h00, 1'b0, 8'h00, txr);
    endtask

    initial begin
        logic [31:0] hi, a;
        logic [17:0] la;
        logic [7:0]  d;
        logic        rdy, wr;
        int          sel;

        for (int i = 0; i < 8; i++)
            pool[i] = (i * 32'h2345 + 32'd7) & 32'h1FFFF;

        do_reset();

        // RAM write then read back, with upper address bits ignored
        wr_cyc(32'h0000_0010, 8'hA5, 1'b0);
        rd_cyc(32'hFFFC_0010, 1'b0);
        chk("ram_a5", 32'(mem_din), 32'hA5);
        idle(1'b0);
        chk("hold_a5", 32'(mem_din), 32'hA5);
        rd_cyc(32'h0002_1234, 1'b0);
        chk("unmapped_rd", 32'(mem_din), 32'h0);

        // tx: zero byte filtered
        wr_cyc(32'h30000, 8'h41, 1'b1);
        wr_cyc(32'h30000, 8'h00, 1'b1);
        wr_cyc(32'h30000, 8'h42, 1'b1);
        repeat (4) idle(1'b1);
        chk("tx_cnt", 32'(dut_sent.size()), 32'd2);
        if (dut_sent.size() == 2) begin
            chk("tx_b0", 32'(dut_sent[0]), 32'h41);
            chk("tx_b1", 32'(dut_sent[1]), 32'h42);
        end

        // Fill: threshold at 14, 17th push dropped
        do_reset();
        for (int i = 1; i <= 17; i++) begin
            wr_cyc(32'h30000, 8'(i), 1'b0);
            if (i == 13) chk("io_full_13", 32'(io_buffer_full), 32'h0);
            if (i == 14) chk("io_full_14", 32'(io_buffer_full), 32'h1);
        end
        repeat (20) idle(1'b1);
        chk("fill_cnt", 32'(dut_sent.size()), 32'd16);
        if (dut_sent.size() == 16)
            chk("fill_last", 32'(dut_sent[15]), 32'd16);

        // Stop sequence
        do_reset();
        wr_cyc(32'h30000, 8'h11, 1'b0);
        wr_cyc(32'h30000, 8'h22, 1'b0);
        wr_cyc(32'h30000, 8'h33, 1'b0);
        wr_cyc(32'h30004, 8'h99, 1'b0);
        wr_cyc(32'h30000, 8'h77, 1'b0);
        chk("done_early", 32'(program_done), 32'h0);
        repeat (8) idle(1'b1);
        chk("stop_cnt", 32'(dut_sent.size()), 32'd4);
        if (dut_sent.size() == 4) begin
            chk("stop_b2", 32'(dut_sent[2]), 32'h33);
            chk("stop_b3", 32'(dut_sent[3]), 32'h00);
        end
        chk("done_final", 32'(program_done), 32'h1);

        // rx holding register
        do_reset();
        cycle(1'b0, 32'h0, 1'b0, 8'h00, 1'b1, 8'h5A, 1'b0);
        chk("rx_busy", 32'(rx_ready), 32'h0);
        rd_cyc(32'h30000, 1'b0);
        chk("rx_rd1", 32'(mem_din), 32'h5A);
        rd_cyc(32'h30000, 1'b0);
        chk("rx_rd2", 32'(mem_din), 32'h00);
        chk("rx_free", 32'(rx_ready), 32'h1);

        // Reset mid-transfer drops queued tx and held rx; RAM is kept
        wr_cyc(32'h30000, 8'h55, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 8'h00, 1'b1, 8'h66, 1'b0);
        do_reset();
        rd_cyc(32'h10, 1'b0);
        chk("ram_kept", 32'(mem_din), 32'hA5);

        // Cycle counter
        do_reset();
        while (m_cnt != 32'h100) idle(1'b0);
        rd_cyc(32'h30004, 1'b0);
        chk("cnt_b0", 32'(mem_din), 32'h00);
        rd_cyc(32'h30005, 1'b0);
`ifdef RAM_IO_CYCLE_COUNTER_EN
        chk("cnt_b1", 32'(mem_din), 32'h01);
`else
        chk("cnt_b1", 32'(mem_din), 32'h00);
`endif
        rd_cyc(32'h30006, 1'b0);
        chk("cnt_b2", 32'(mem_din), 32'h00);
        rd_cyc(32'h30007, 1'b0);
        chk("cnt_b3", 32'(mem_din), 32'h00);

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 8; i++)
            wr_cyc(pool[i], 8'($urandom()), 1'b0);
        for (int n = 0; n < 500; n++) begin
            hi  = $urandom();
            sel = int'($urandom_range(0, 9));
            rdy = ($urandom_range(0, 3) != 0);
            wr  = 1'($urandom_range(0, 1));
            d   = 8'($urandom());
            if (sel <= 4)
                la = pool[$urandom_range(0, 7)][17:0];
            else if (sel == 5 || sel == 9) begin
                la = 18'h30000;
                if ($urandom_range(0, 3) == 0) d = 8'h00;
            end
            else if (sel == 6) begin
                la = 18'h30004 + 18'($urandom_range(0, 3));
                wr = 1'b0;
            end
            else if (sel == 7)
                la = 18'h20000 | 18'($urandom_range(0, 16'hFFFF));
            else
                la = 18'h30008 + 18'($urandom_range(0, 12'hFFF));
            a = {hi[31:18], la};
            cycle(rdy, a, wr, d, 1'($urandom_range(0, 3) == 0), 8'($urandom()),
                  1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
